// File: rtl/reset_sequencer_pkg.sv
// Shared constants for the synth reset chain: FSM encodings, width helpers, 50 MHz defaults.
package reset_sequencer_pkg;

  localparam logic [1:0] ST_SYNC    = 2'd0;
  localparam logic [1:0] ST_STAGGER = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  localparam int DEF_NUM_DOMAINS  = 4;
  localparam int DEF_STAGE_CYCLES = 1024;  // 20.48 us at 50 MHz
  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_SOFT_HOLD    = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Register width for values 0..v-1, never narrower than one bit.
  function automatic int bits(input int v);
    return max2(1, clog2(v));
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset-deassert synchronizer: async set, releases STAGES rising edges after reset falls.
// Latency: STAGES clk edges on release, none on assert. No backpressure.
module reset_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  output logic rst_sync
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '1;
    end else begin
      chain <= {chain[STAGES-2:0], 1'b0};
    end
  end

  assign rst_sync = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Per-domain reset sequencer: async assert, staggered synchronous release, soft-reset restart.
// Latency: domain k free SYNC_STAGES+(k+1)*STAGE_CYCLES edges after reset; ready one edge later.
// Backpressure: soft_req is a level, accepted only in RUN and acknowledged with a one-cycle pulse.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_DOMAINS  = DEF_NUM_DOMAINS,
  parameter int STAGE_CYCLES = DEF_STAGE_CYCLES,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int SOFT_HOLD    = DEF_SOFT_HOLD,
  localparam int STW = bits(NUM_DOMAINS + 1),
  localparam int CW  = bits(max2(STAGE_CYCLES, SOFT_HOLD))
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   soft_req,
  output logic                   soft_ack,
  output logic [NUM_DOMAINS-1:0] domain_reset,
  output logic                   ready,
  output logic [STW-1:0]         stage
);

  localparam logic [CW-1:0]  STAGE_TC  = CW'(STAGE_CYCLES - 1);
  localparam logic [CW-1:0]  HOLD_TC   = CW'(SOFT_HOLD - 1);
  localparam logic [STW-1:0] LAST_STAGE = STW'(NUM_DOMAINS - 1);

  logic          rst_sync;
  logic [1:0]    state;
  logic [CW-1:0] counter;

  reset_sync #(
    .STAGES (SYNC_STAGES)
  ) u_reset_sync (
    .clk      (clk),
    .reset    (reset),
    .rst_sync (rst_sync)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_SYNC;
      counter      <= '0;
      stage        <= '0;
      domain_reset <= '1;
      ready        <= 1'b0;
      soft_ack     <= 1'b0;
    end else begin
      soft_ack <= 1'b0;
      case (state)
        ST_SYNC: begin
          // The edge that observes rst_sync low is cycle 0 of stage 0, so domain 0
          // frees exactly SYNC_STAGES+STAGE_CYCLES edges after reset falls.
          if (!rst_sync) begin
            state   <= ST_STAGGER;
            counter <= CW'(1);
          end
        end
        ST_STAGGER: begin
          if (counter == STAGE_TC) begin
            // Shifting zeros in from bit 0 keeps the {1..1,0..0} release order.
            domain_reset <= domain_reset << 1;
            stage        <= stage + 1'b1;
            counter      <= '0;
            if (stage == LAST_STAGE) state <= ST_RUN;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        ST_RUN: begin
          if (soft_req) begin
            soft_ack     <= 1'b1;
            domain_reset <= '1;
            ready        <= 1'b0;
            stage        <= '0;
            counter      <= '0;
            state        <= ST_HOLD;
          end else begin
            ready <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (counter == HOLD_TC) begin
            counter <= '0;
            state   <= ST_STAGGER;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: state <= ST_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: main instance (4 domains, 8-cycle stages) plus a 1-domain corner instance.
module tb_reset_sequencer;

  logic       clk;
  logic       reset;
  logic       soft_req;
  logic       soft_ack;
  logic [3:0] domain_reset;
  logic       ready;
  logic [2:0] stage;

  logic       reset1;
  logic       soft_req1;
  logic       soft_ack1;
  logic [0:0] domain_reset1;
  logic       ready1;
  logic [0:0] stage1;

  int checks;
  int failures;

  reset_sequencer #(
    .NUM_DOMAINS  (4),
    .STAGE_CYCLES (8),
    .SYNC_STAGES  (2),
    .SOFT_HOLD    (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .soft_req     (soft_req),
    .soft_ack     (soft_ack),
    .domain_reset (domain_reset),
    .ready        (ready),
    .stage        (stage)
  );

  reset_sequencer #(
    .NUM_DOMAINS  (1),
    .STAGE_CYCLES (2),
    .SYNC_STAGES  (2),
    .SOFT_HOLD    (4)
  ) dut1 (
    .clk          (clk),
    .reset        (reset1),
    .soft_req     (soft_req1),
    .soft_ack     (soft_ack1),
    .domain_reset (domain_reset1),
    .ready        (ready1),
    .stage        (stage1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected main-instance outputs at edge n after reset release (n<=0: still in reset).
  function automatic logic [3:0] exp_dr(input int n);
    if (n < 10)      return 4'b1111;
    else if (n < 18) return 4'b1110;
    else if (n < 26) return 4'b1100;
    else if (n < 34) return 4'b1000;
    else             return 4'b0000;
  endfunction

  function automatic logic [2:0] exp_stage(input int n);
    if (n < 10)      return 3'd0;
    else if (n < 18) return 3'd1;
    else if (n < 26) return 3'd2;
    else if (n < 34) return 3'd3;
    else             return 3'd4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-period, verify the asynchronous reset state, hold, release at a falling edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk({tag, " rst domain_reset"}, 32'(domain_reset), 32'hF);
    chk({tag, " rst ready"}, 32'(ready), 32'h0);
    chk({tag, " rst stage"}, 32'(stage), 32'h0);
    chk({tag, " rst soft_ack"}, 32'(soft_ack), 32'h0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Step through edges k=1..last_n+shift; outputs follow the release schedule at n=k-shift.
  task automatic run_and_check(input string tag, input int shift, input int last_n,
                               input int req_on, input int req_off);
    int n;
    for (int k = 1; k <= last_n + shift; k++) begin
      tick();
      n = k - shift;
      chk($sformatf("%s n=%0d domain_reset", tag, n), 32'(domain_reset), 32'(exp_dr(n)));
      chk($sformatf("%s n=%0d stage", tag, n), 32'(stage), 32'(exp_stage(n)));
      chk($sformatf("%s n=%0d ready", tag, n), 32'(ready), 32'(n >= 35));
      chk($sformatf("%s n=%0d soft_ack", tag, n), 32'(soft_ack), 32'h0);
      if (n == req_on)  soft_req = 1'b1;
      if (n == req_off) soft_req = 1'b0;
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    reset1    = 1'b0;
    soft_req  = 1'b0;
    soft_req1 = 1'b0;
    #2;
    reset1 = 1'b1;

    // Power-up release and full stagger.
    do_reset("t1");
    run_and_check("t1", 0, 36, -1, -1);

    // Reset pulse in the middle of the stagger, then a clean repeat.
    do_reset("t2a");
    run_and_check("t2a", 0, 21, -1, -1);
    do_reset("t2b");
    run_and_check("t2b", 0, 36, -1, -1);

    // Single-cycle soft request in RUN.
    soft_req = 1'b1;
    tick();
    chk("t3 ack soft_ack", 32'(soft_ack), 32'h1);
    chk("t3 ack domain_reset", 32'(domain_reset), 32'hF);
    chk("t3 ack ready", 32'(ready), 32'h0);
    chk("t3 ack stage", 32'(stage), 32'h0);
    soft_req = 1'b0;
    run_and_check("t3", 2, 36, -1, -1);

    // Soft request raised and dropped during stagger is ignored.
    do_reset("t4");
    run_and_check("t4", 0, 36, 12, 30);

    // Held soft request cycles every 37 edges; reset during HOLD goes back to SYNC.
    soft_req = 1'b1;
    tick();
    chk("t5 first soft_ack", 32'(soft_ack), 32'h1);
    for (int k = 1; k <= 74; k++) begin
      tick();
      chk($sformatf("t5 k=%0d soft_ack", k), 32'(soft_ack), 32'((k == 37) || (k == 74)));
      chk($sformatf("t5 k=%0d ready", k), 32'(ready), 32'h0);
    end
    repeat (2) tick();
    chk("t5 hold domain_reset", 32'(domain_reset), 32'hF);
    do_reset("t5");
    soft_req = 1'b0;
    run_and_check("t5r", 0, 36, -1, -1);

    // Single-domain corner: release at edge 4, ready at edge 5.
    chk("t6 rst domain_reset", 32'(domain_reset1), 32'h1);
    chk("t6 rst ready", 32'(ready1), 32'h0);
    @(negedge clk);
    reset1 = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      tick();
      chk($sformatf("t6 n=%0d domain_reset", n), 32'(domain_reset1), 32'(n < 4));
      chk($sformatf("t6 n=%0d stage", n), 32'(stage1), 32'(n >= 4));
      chk($sformatf("t6 n=%0d ready", n), 32'(ready1), 32'(n >= 5));
      chk($sformatf("t6 n=%0d soft_ack", n), 32'(soft_ack1), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
